// File: rtl/svnet_fifo_packer.sv
// Packs RATIO narrow words from an upstream FIFO into one wide word for a downstream FIFO.
// A flush request emits the current partial word with per-lane keep bits.
module svnet_fifo_packer #(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(IN_DEPTH):0]     in_used_space,
  input  logic [WIDTH-1:0]              in_read_data,
  output logic                          in_read,
  input  logic [$clog2(OUT_DEPTH):0]    out_free_space,
  output logic                          out_write,
  output logic [WIDTH*RATIO-1:0]        out_write_data,
  output logic [RATIO-1:0]              out_keep,
  input  logic                          flush,
  output logic                          busy
);

  localparam int CW = $clog2(RATIO);
  localparam int LW = (RATIO-1)*WIDTH;
  localparam logic [CW-1:0] LAST = CW'(RATIO-1);

  logic [LW-1:0]          r_lanes;
  logic [CW-1:0]          r_count;
  logic [WIDTH*RATIO-1:0] r_out_data;
  logic [RATIO-1:0]       r_out_keep;
  logic                   r_out_valid;
  logic                   r_flush_pending;

  logic                   w_out_free;
  logic                   w_full_load;
  logic                   w_flush_set;
  logic                   w_flush_emit;
  logic                   w_flush_clear;
  logic [WIDTH*RATIO-1:0] w_partial_data;
  logic [RATIO-1:0]       w_partial_keep;

  // in_read is gated by rst_n so every output is quiet while reset is held
  assign out_write      = r_out_valid && (out_free_space != '0);
  assign out_write_data = r_out_data;
  assign out_keep       = r_out_keep;
  assign w_out_free     = !r_out_valid || out_write;
  assign in_read        = rst_n && (in_used_space != '0) && !r_flush_pending &&
                          ((r_count != LAST) || w_out_free);
  assign w_full_load    = in_read && (r_count == LAST);
  assign w_flush_set    = flush && !r_flush_pending && ((r_count != '0) || in_read);
  assign w_flush_emit   = r_flush_pending && (r_count != '0) && w_out_free;
  assign w_flush_clear  = r_flush_pending && ((r_count == '0) || w_out_free);
  assign busy           = (r_count != '0) || r_out_valid || r_flush_pending;

  always_comb begin
    w_partial_data = '0;
    w_partial_keep = '0;
    for (int k = 0; k < RATIO-1; k++) begin
      if (k < int'(r_count)) begin
        w_partial_data[k*WIDTH +: WIDTH] = r_lanes[k*WIDTH +: WIDTH];
        w_partial_keep[k]                = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lanes         <= '0;
      r_count         <= '0;
      r_out_data      <= '0;
      r_out_keep      <= '0;
      r_out_valid     <= 1'b0;
      r_flush_pending <= 1'b0;
    end else begin
      if (in_read && !w_full_load) begin
        r_lanes[int'(r_count)*WIDTH +: WIDTH] <= in_read_data;
        r_count <= r_count + CW'(1);
      end else if (w_full_load || w_flush_emit) begin
        r_count <= '0;
      end

      // A new load wins over the clear caused by a write in the same cycle
      if (w_full_load) begin
        r_out_data  <= {in_read_data, r_lanes};
        r_out_keep  <= '1;
        r_out_valid <= 1'b1;
      end else if (w_flush_emit) begin
        r_out_data  <= w_partial_data;
        r_out_keep  <= w_partial_keep;
        r_out_valid <= 1'b1;
      end else if (out_write) begin
        r_out_valid <= 1'b0;
      end

      if (w_flush_set) begin
        r_flush_pending <= 1'b1;
      end else if (w_flush_clear) begin
        r_flush_pending <= 1'b0;
      end
    end
  end

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    in_read |-> (in_used_space != '0));
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    out_write |-> (out_free_space != '0));

endmodule

// File: tb/tb_svnet_fifo_packer.sv
// Directed and randomized bench for svnet_fifo_packer (WIDTH=8, RATIO=4).
// Upstream and downstream FIFOs are modelled with queues driven on the falling edge.
module tb_svnet_fifo_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int IN_DEPTH = 16;
  localparam int OUT_DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       in_used_space = '0;
  logic [7:0]       in_read_data = '0;
  logic             in_read;
  logic [4:0]       out_free_space = '0;
  logic             out_write;
  logic [31:0]      out_write_data;
  logic [3:0]       out_keep;
  logic             flush = 1'b0;
  logic             busy;

  int assertsEval = 0;
  int failCount = 0;
  int cycle = 0;
  int readCount = 0;
  int firstRead = 0;
  int lastRead = 0;
  int freeSpace = 0;
  bit flushReq = 1'b0;
  logic [7:0]  upQ[$];
  logic [7:0]  expQ[$];
  logic [31:0] outData[$];
  logic [3:0]  outKeep[$];
  int          writeCycle[$];

  svnet_fifo_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_used_space(in_used_space), .in_read_data(in_read_data),
    .in_read(in_read), .out_free_space(out_free_space), .out_write(out_write),
    .out_write_data(out_write_data), .out_keep(out_keep), .flush(flush), .busy(busy));

  always #5 clk = ~clk;

  // One clock: drive inputs from the models at negedge, sample just after, update models
  task automatic step();
    @(negedge clk);
    in_used_space  = 5'(upQ.size());
    in_read_data   = (upQ.size() != 0) ? upQ[0] : 8'($urandom);
    out_free_space = 5'(freeSpace);
    flush          = flushReq;
    flushReq       = 1'b0;
    #1;
    if (in_read) begin
      if (upQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL read_on_empty: in_read=1 required 0 at cycle %0d", cycle);
      end else begin
        void'(upQ.pop_front());
      end
      if (readCount == 0) firstRead = cycle;
      lastRead = cycle;
      readCount++;
    end
    if (out_write) begin
      outData.push_back(out_write_data);
      outKeep.push_back(out_keep);
      writeCycle.push_back(cycle);
    end
    cycle++;
  endtask

  task automatic clearLog();
    readCount = 0;
    outData.delete();
    outKeep.delete();
    writeCycle.delete();
  endtask

  task automatic test_reset();
    in_used_space  = 5'd3;
    out_free_space = 5'd4;
    repeat (2) @(negedge clk);
    #1;
    assertsEval++;
    if (in_read !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in_read: got %b required 0", in_read); end
    assertsEval++;
    if (out_write !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_write: got %b required 0", out_write); end
    assertsEval++;
    if (out_write_data !== 32'h0) begin failCount++; $display("[TB] FAIL reset_data: got %h required 0", out_write_data); end
    assertsEval++;
    if (out_keep !== 4'h0) begin failCount++; $display("[TB] FAIL reset_keep: got %h required 0", out_keep); end
    assertsEval++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    @(negedge clk);
    in_used_space = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    clearLog();
    freeSpace = 4;
    for (int i = 1; i <= 8; i++) upQ.push_back(8'(i));
    repeat (14) step();
    assertsEval++;
    if (readCount != 8) begin failCount++; $display("[TB] FAIL stream_reads: got %0d required 8", readCount); end
    assertsEval++;
    if (lastRead - firstRead != 7) begin failCount++; $display("[TB] FAIL stream_consecutive: span %0d required 7", lastRead - firstRead); end
    assertsEval++;
    if (outData.size() != 2) begin
      failCount++; $display("[TB] FAIL stream_writes: got %0d required 2", outData.size());
    end else begin
      assertsEval++;
      if (outData[0] !== 32'h04030201) begin failCount++; $display("[TB] FAIL stream_word0: got %h required 04030201", outData[0]); end
      assertsEval++;
      if (outData[1] !== 32'h08070605) begin failCount++; $display("[TB] FAIL stream_word1: got %h required 08070605", outData[1]); end
      assertsEval++;
      if (outKeep[0] !== 4'hF || outKeep[1] !== 4'hF) begin failCount++; $display("[TB] FAIL stream_keep: got %h,%h required F,F", outKeep[0], outKeep[1]); end
      assertsEval++;
      if (writeCycle[0] - firstRead != 4) begin failCount++; $display("[TB] FAIL stream_latency: got %0d required 4", writeCycle[0] - firstRead); end
    end
    assertsEval++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL stream_busy: got %b required 0", busy); end
  endtask

  task automatic test_flush();
    clearLog();
    freeSpace = 4;
    upQ.push_back(8'hA1); upQ.push_back(8'hA2); upQ.push_back(8'hA3);
    repeat (6) step();
    assertsEval++;
    if (readCount != 3 || outData.size() != 0 || busy !== 1'b1) begin
      failCount++; $display("[TB] FAIL flush_hold: reads=%0d writes=%0d busy=%b required 3,0,1", readCount, outData.size(), busy);
    end
    flushReq = 1'b1;
    repeat (6) step();
    assertsEval++;
    if (outData.size() != 1) begin
      failCount++; $display("[TB] FAIL flush_writes: got %0d required 1", outData.size());
    end else begin
      assertsEval++;
      if (outData[0] !== 32'h00A3A2A1) begin failCount++; $display("[TB] FAIL flush_data: got %h required 00A3A2A1", outData[0]); end
      assertsEval++;
      if (outKeep[0] !== 4'h7) begin failCount++; $display("[TB] FAIL flush_keep: got %h required 7", outKeep[0]); end
    end
    assertsEval++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL flush_busy: got %b required 0", busy); end
    flushReq = 1'b1;
    repeat (6) step();
    assertsEval++;
    if (outData.size() != 1) begin failCount++; $display("[TB] FAIL flush_second_noop: writes %0d required 1", outData.size()); end
  endtask

  task automatic test_back_pressure();
    clearLog();
    freeSpace = 0;
    for (int i = 1; i <= 12; i++) upQ.push_back(8'(i));
    repeat (20) step();
    assertsEval++;
    if (readCount != 7) begin failCount++; $display("[TB] FAIL bp_reads: got %0d required 7", readCount); end
    assertsEval++;
    if (outData.size() != 0) begin failCount++; $display("[TB] FAIL bp_no_write: got %0d writes required 0", outData.size()); end
    freeSpace = 2;
    repeat (20) step();
    assertsEval++;
    if (readCount != 12 || upQ.size() != 0) begin failCount++; $display("[TB] FAIL bp_resume: reads=%0d left=%0d required 12,0", readCount, upQ.size()); end
    assertsEval++;
    if (outData.size() != 3) begin
      failCount++; $display("[TB] FAIL bp_writes: got %0d required 3", outData.size());
    end else begin
      assertsEval++;
      if (outData[0] !== 32'h04030201 || outData[1] !== 32'h08070605 || outData[2] !== 32'h0C0B0A09) begin
        failCount++; $display("[TB] FAIL bp_data: got %h %h %h required 04030201 08070605 0C0B0A09", outData[0], outData[1], outData[2]);
      end
      assertsEval++;
      if (outKeep[0] !== 4'hF || outKeep[1] !== 4'hF || outKeep[2] !== 4'hF) begin
        failCount++; $display("[TB] FAIL bp_keep: got %h %h %h required F F F", outKeep[0], outKeep[1], outKeep[2]);
      end
    end
  endtask

  task automatic test_flush_with_last();
    clearLog();
    freeSpace = 4;
    upQ.push_back(8'hB1); upQ.push_back(8'hB2); upQ.push_back(8'hB3);
    repeat (5) step();
    upQ.push_back(8'hB4);
    flushReq = 1'b1;
    repeat (8) step();
    assertsEval++;
    if (outData.size() != 1) begin
      failCount++; $display("[TB] FAIL flast_writes: got %0d required 1", outData.size());
    end else begin
      assertsEval++;
      if (outData[0] !== 32'hB4B3B2B1 || outKeep[0] !== 4'hF) begin
        failCount++; $display("[TB] FAIL flast_word: got %h/%h required B4B3B2B1/F", outData[0], outKeep[0]);
      end
    end
    assertsEval++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL flast_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_word();
    clearLog();
    freeSpace = 0;
    for (int i = 1; i <= 6; i++) upQ.push_back(8'(8'h10 + i));
    repeat (10) step();
    assertsEval++;
    if (readCount != 6 || busy !== 1'b1) begin failCount++; $display("[TB] FAIL rst_setup: reads=%0d busy=%b required 6,1", readCount, busy); end
    @(negedge clk);
    rst_n = 1'b0;
    in_used_space = 5'd4;
    in_read_data = 8'h55;
    out_free_space = 5'd4;
    #1;
    assertsEval++;
    if (in_read !== 1'b0 || out_write !== 1'b0) begin failCount++; $display("[TB] FAIL rst_strobes: read=%b write=%b required 0,0", in_read, out_write); end
    assertsEval++;
    if (out_write_data !== 32'h0 || out_keep !== 4'h0) begin failCount++; $display("[TB] FAIL rst_outputs: data=%h keep=%h required 0,0", out_write_data, out_keep); end
    assertsEval++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
    @(negedge clk);
    in_used_space = '0;
    rst_n = 1'b1;
    upQ.delete();
    freeSpace = 4;
    repeat (10) step();
    assertsEval++;
    if (outData.size() != 0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_stale: writes=%0d busy=%b required 0,0", outData.size(), busy); end
  endtask

  // Unpack every captured write lane by lane and match it against the pushed stream
  task automatic scoreWrites();
    logic [31:0] d;
    logic [3:0]  k;
    bit          ok;
    while (outData.size() != 0) begin
      d = outData.pop_front();
      k = outKeep.pop_front();
      ok = (k == 4'h1 || k == 4'h3 || k == 4'h7 || k == 4'hF);
      for (int l = 0; l < RATIO; l++) begin
        if (k[l]) begin
          if (expQ.size() == 0) ok = 1'b0;
          else if (d[l*8 +: 8] !== expQ.pop_front()) ok = 1'b0;
        end else if (d[l*8 +: 8] !== 8'h0) begin
          ok = 1'b0;
        end
      end
      assertsEval++;
      if (!ok) begin failCount++; $display("[TB] FAIL rand_word: got %h keep %h, not the next in-order lanes", d, k); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    clearLog();
    expQ.delete();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 1) == 1 && upQ.size() < IN_DEPTH) begin
        b = 8'($urandom);
        upQ.push_back(b);
        expQ.push_back(b);
      end
      freeSpace = $urandom_range(0, 3);
      flushReq = ($urandom_range(0, 39) == 0);
      step();
      scoreWrites();
    end
    freeSpace = 4;
    repeat (20) step();
    flushReq = 1'b1;
    repeat (10) step();
    scoreWrites();
    assertsEval++;
    if (expQ.size() != 0 || upQ.size() != 0) begin failCount++; $display("[TB] FAIL rand_lost: %0d words unwritten, %0d unread, required 0", expQ.size(), upQ.size()); end
    assertsEval++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL final_busy: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush();
    test_back_pressure();
    test_flush_with_last();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertsEval, failCount);
    $finish;
  end

endmodule
